// File: rtl/perm_pkg.sv
// Shared definitions for the permutation sequencer: sizes, default RNG seed,
// FSM state encoding and the small arithmetic helpers used by the datapath.
package perm_pkg;

  localparam int          N_ELEM   = 16;
  localparam int          ENT_W    = 4;
  localparam logic [31:0] DEF_SEED = 32'h92D68CA2;
  localparam logic [63:0] IDENT_SEQ = 64'h0123456789ABCDEF;

  typedef logic [ENT_W-1:0] entry_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    SHUF = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } state_t;

  // One xorshift32 step (13, 17, 5).
  function automatic logic [31:0] xs32_step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Scaled pick: bits [19:16] of rnd[15:0]*(i+1) always lie in 0..i.
  function automatic entry_t pick_j(input logic [31:0] rnd, input entry_t i);
    logic [20:0] p;
    p = 21'(rnd[15:0]) * 21'({1'b0, i} + 5'd1);
    return p[19:16];
  endfunction

  // Entry idx of a packed sequence (entry 0 in the top nibble).
  function automatic entry_t entry_at(input logic [63:0] s, input entry_t idx);
    int sh;
    sh = 4 * (15 - int'(idx));
    return s[sh +: 4];
  endfunction

endpackage

// File: rtl/perm_seq_ctrl_if.sv
// Valid/ready output stream carrying one permutation entry per beat.
interface perm_seq_ctrl_if;
  import perm_pkg::*;

  logic   out_valid;
  logic   out_ready;
  entry_t out_data;
  logic   out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);

endinterface

// File: rtl/xorshift32_ld.sv
// Loadable xorshift32 generator; a zero seed is replaced by DEF_SEED because
// the all-zero state never leaves zero.
module xorshift32_ld #(
  parameter logic [31:0] DEF_SEED = perm_pkg::DEF_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] res
);

  logic [31:0] x_q;

  // Generator state: reset/load take priority over stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= DEF_SEED;
    end else if (load) begin
      x_q <= (seed == 32'd0) ? DEF_SEED : seed;
    end else if (step) begin
      x_q <= perm_pkg::xs32_step(x_q);
    end
  end

  assign res = x_q;

endmodule

// File: rtl/perm_seq_ctrl.sv
// Permutation sequencer: builds a Fisher-Yates shuffle of 0..15 one swap per
// cycle, then streams the entries out over a valid/ready interface.
module perm_seq_ctrl
  import perm_pkg::*;
#(
  parameter int          N_ELEM   = perm_pkg::N_ELEM,
  parameter logic [31:0] DEF_SEED = perm_pkg::DEF_SEED
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    seed_load,
  input  logic [31:0]             seed,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [63:0]             seq_all,
  perm_seq_ctrl_if.master         out_if
);

  state_t      state_q;
  entry_t      arr_q [N_ELEM];
  entry_t      arr_sw [N_ELEM];
  entry_t      i_q;
  entry_t      idx_q;
  entry_t      j;
  entry_t      data_q;
  logic        busy_q;
  logic        done_q;
  logic        valid_q;
  logic        last_q;
  logic [63:0] seq_q;
  logic [63:0] seq_sw;
  logic [31:0] rnd;
  logic        rng_load;
  logic        rng_step;

  // Seeds are only accepted while idle; the RNG only advances while shuffling.
  assign rng_load = (state_q == IDLE) && seed_load;
  assign rng_step = (state_q == SHUF);

  xorshift32_ld #(.DEF_SEED(DEF_SEED)) u_rng (
    .clk  (clk),
    .rst  (rst),
    .load (rng_load),
    .seed (seed),
    .step (rng_step),
    .res  (rnd)
  );

  assign j = pick_j(rnd, i_q);

  // Working array after swapping entries i and j (j == i leaves it unchanged).
  always_comb begin
    seq_sw = '0;
    for (int k = 0; k < N_ELEM; k++) begin
      if (entry_t'(k) == i_q) begin
        arr_sw[k] = arr_q[j];
      end else if (entry_t'(k) == j) begin
        arr_sw[k] = arr_q[i_q];
      end else begin
        arr_sw[k] = arr_q[k];
      end
      seq_sw[4*(N_ELEM-1-k) +: 4] = arr_sw[k];
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      seq_q   <= IDENT_SEQ;
      i_q     <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= INIT;
            busy_q  <= 1'b1;
          end
        end
        INIT: begin
          for (int k = 0; k < N_ELEM; k++) begin
            arr_q[k] <= entry_t'(k);
          end
          i_q     <= entry_t'(N_ELEM - 1);
          state_q <= SHUF;
        end
        SHUF: begin
          for (int k = 0; k < N_ELEM; k++) begin
            arr_q[k] <= arr_sw[k];
          end
          i_q <= i_q - 1'b1;
          // The i=1 swap is the last one; the result is published directly.
          if (i_q == entry_t'(1)) begin
            state_q <= EMIT;
            seq_q   <= seq_sw;
            valid_q <= 1'b1;
            data_q  <= arr_sw[0];
            last_q  <= 1'b0;
            idx_q   <= '0;
          end
        end
        EMIT: begin
          if (valid_q && out_if.out_ready) begin
            if (idx_q == entry_t'(N_ELEM - 1)) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q  <= idx_q + 1'b1;
              data_q <= entry_at(seq_q, idx_q + 1'b1);
              last_q <= (idx_q == entry_t'(N_ELEM - 2));
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign seq_all          = seq_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_last  = last_q;

endmodule

// File: tb/tb_perm_seq_ctrl.sv
// Directed bench for perm_seq_ctrl: reset state, latency, stream content,
// back-pressure, ignored requests while busy, mid-run reset and zero seed.
module tb_perm_seq_ctrl;

  localparam logic [63:0] IDENT = 64'h0123456789ABCDEF;
  localparam logic [31:0] DEF   = 32'h92D68CA2;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [31:0] seed;
  logic        start;
  logic        busy;
  logic        done;
  logic [63:0] seq_all;

  perm_seq_ctrl_if bus();

  perm_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed      (seed),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .seq_all   (seq_all),
    .out_if    (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] rng_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference shuffle from a starting generator state; fin is the state after 15 steps.
  function automatic logic [63:0] model_perm(input logic [31:0] s, output logic [31:0] fin);
    logic [3:0]  a [16];
    logic [31:0] x;
    logic [31:0] p;
    logic [3:0]  jj;
    logic [3:0]  t;
    logic [63:0] r;
    x = s;
    for (int k = 0; k < 16; k++) a[k] = 4'(k);
    for (int i = 15; i >= 1; i--) begin
      p  = {16'd0, x[15:0]} * 32'(i + 1);
      jj = p[19:16];
      t     = a[i];
      a[i]  = a[jj];
      a[jj] = t;
      x = x ^ (x << 13);
      x = x ^ (x >> 17);
      x = x ^ (x << 5);
    end
    r = '0;
    for (int k = 0; k < 16; k++) r[4*(15-k) +: 4] = a[k];
    fin = x;
    return r;
  endfunction

  // mode 0: always ready; 1: stall 5 cycles at beat 3 then toggle;
  // 2: start/seed_load pulses while busy.
  task automatic run(input bit do_load, input logic [31:0] ld_seed, input int mode,
                     output logic [63:0] got);
    logic [63:0] exp;
    logic [31:0] st;
    logic [31:0] fin;
    logic [4:0]  prev;
    logic [15:0] mask;
    bit          prev_stalled;
    bit          inj;
    int          n;
    int          k;
    int          cyc;
    int          stall;
    st  = do_load ? ((ld_seed == 32'd0) ? DEF : ld_seed) : rng_m;
    exp = model_perm(st, fin);
    rng_m = fin;

    seed_load = do_load;
    seed      = ld_seed;
    start     = 1'b1;
    tick();
    seed_load = 1'b0;
    start     = 1'b0;

    n = 0;
    while (!bus.out_valid && n < 40) begin
      start = (mode == 2 && n == 5);
      tick();
      n++;
    end
    start = 1'b0;
    check("latency", 64'(n), 64'd16);
    check("seq_all_at_emit", seq_all, exp);

    k = 0; cyc = 0; stall = 0; inj = 0; mask = '0;
    prev = '0; prev_stalled = 0;
    bus.out_ready = 1'b1;
    while (k < 16 && cyc < 300) begin
      if (bus.out_valid && prev_stalled)
        check("hold", 64'({bus.out_last, bus.out_data}), 64'(prev));
      start = 1'b0;
      seed_load = 1'b0;
      if (mode == 1) begin
        if (k < 3) bus.out_ready = 1'b1;
        else if (stall < 5) begin bus.out_ready = 1'b0; stall++; end
        else bus.out_ready = ~bus.out_ready;
      end else if (mode == 2 && k == 2 && !inj) begin
        bus.out_ready = 1'b0;
        start = 1'b1;
        seed_load = 1'b1;
        seed = 32'hDEADBEEF;
        inj = 1;
      end else begin
        bus.out_ready = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        check("beat_data", 64'(bus.out_data), 64'(exp[4*(15-k) +: 4]));
        check("beat_last", 64'(bus.out_last), 64'(k == 15));
        mask = mask | (16'd1 << bus.out_data);
        k++;
      end
      prev = {bus.out_last, bus.out_data};
      prev_stalled = bus.out_valid && !bus.out_ready;
      tick();
      cyc++;
    end
    start = 1'b0;
    seed_load = 1'b0;
    check("beat_count", 64'(k), 64'd16);
    check("distinct", 64'(mask), 64'hFFFF);
    check("done_pulse", 64'({done, bus.out_valid}), 64'b10);
    bus.out_ready = 1'b0;
    tick();
    check("done_end", 64'({done, busy}), 64'b00);
    check("seq_all_hold", seq_all, exp);
    if (mode == 2) begin
      for (int c = 0; c < 4; c++) begin
        check("no_rerun", 64'({busy, bus.out_valid}), 64'b00);
        tick();
      end
    end
    got = seq_all;
  endtask

  logic [63:0] s_a;
  logic [63:0] s_b;
  logic [63:0] s_c;
  int          n0;
  int          kb;

  initial begin
    rst = 1'b1; seed_load = 1'b0; seed = '0; start = 1'b1; bus.out_ready = 1'b0;
    rng_m = DEF;
    tick();
    tick();
    start = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_last", 64'(bus.out_last), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_data", 64'(bus.out_data), 64'd0);
    check("rst_seq", seq_all, IDENT);
    rst = 1'b0;
    tick();
    check("idle_busy", 64'(busy), 64'd0);

    // Seed 1 twice (second run under back-pressure), then seed 2.
    run(1'b1, 32'h1, 0, s_a);
    run(1'b1, 32'h1, 1, s_b);
    check("repeat_same", s_b, s_a);
    run(1'b1, 32'h2, 0, s_c);
    check("seed2_differs", 64'(s_c != s_a), 64'd1);

    // Requests while busy are ignored; the next run continues the same RNG.
    run(1'b1, 32'h1, 2, s_b);
    check("inj_same", s_b, s_a);
    run(1'b0, 32'h0, 0, s_b);

    // Reset in the middle of streaming.
    seed_load = 1'b1; seed = 32'h1; start = 1'b1;
    tick();
    seed_load = 1'b0; start = 1'b0;
    n0 = 0;
    while (!bus.out_valid && n0 < 40) begin tick(); n0++; end
    bus.out_ready = 1'b1;
    kb = 0; n0 = 0;
    while (kb < 8 && n0 < 50) begin
      if (bus.out_valid && bus.out_ready) kb++;
      tick();
      n0++;
    end
    check("pre_rst_beats", 64'(kb), 64'd8);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_seq", seq_all, IDENT);
    rst = 1'b0;
    rng_m = DEF;
    tick();
    check("mid_rst_done", 64'(done), 64'd0);

    // Fresh run after reset uses DEF_SEED; a zero seed must give the same result.
    run(1'b0, 32'h0, 0, s_a);
    rng_m = DEF;
    run(1'b1, 32'h0, 0, s_b);
    check("zero_seed", s_b, s_a);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/perm_seq_ctrl.md
PERM_SEQ_CTRL -- requirements
Module: perm_seq_ctrl

Interface
REQ-001 SHALL have parameter N_ELEM, default 16, meaning number of permutation entries; fixed at 16 in this revision.
REQ-002 SHALL have parameter DEF_SEED, default 32'h92D68CA2, meaning the RNG state after reset and the substitute for a zero seed.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port seed_load, input, 1 bit: load seed into the RNG; honoured only in IDLE.
REQ-006 SHALL have port seed, input, 32 bits: RNG seed value.
REQ-007 SHALL have port start, input, 1 bit: request a new permutation; honoured only in IDLE.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data holds a valid entry.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the entry.
REQ-011 SHALL have port out_data, output, 4 bits: current permutation entry.
REQ-012 SHALL have port out_last, output, 1 bit: high with the 16th entry.
REQ-013 SHALL have port seq_all, output, 64 bits: full permutation, entry 0 in [63:60] and entry 15 in [3:0].
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse after the last beat is accepted.

Function
REQ-015 SHALL implement FSM states IDLE, INIT, SHUF, EMIT and DONE.
REQ-016 SHALL move IDLE->INIT on the edge where start=1; if seed_load=1 on the same edge, seed_load SHALL take effect and then start SHALL proceed.
REQ-017 In INIT (1 cycle), SHALL load the working array with identity (entry k=k), set index i=15, then go to SHUF.
REQ-018 In SHUF, each cycle SHALL compute j = bits[19:16] of (rnd[15:0] * (i+1)), which guarantees 0<=j<=i.
REQ-019 In SHUF, each cycle SHALL swap entries i and j, step the RNG once, and decrement i.
REQ-020 SHALL leave SHUF for EMIT after the i=1 swap, so SHUF lasts exactly 15 cycles; j=i is a legal no-op swap.
REQ-021 SHALL make out_valid high 16 rising edges after the edge that sampled start.
REQ-022 In EMIT, SHALL present entries 0..15 in order; a beat transfers on an edge with out_valid&out_ready.
REQ-023 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-024 SHALL not make out_valid depend combinationally on out_ready.
REQ-025 SHALL go EMIT->DONE when the out_last beat transfers; DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-026 SHALL update seq_all on the EMIT entry edge and hold it until the next INIT; seq_all SHALL equal the emitted sequence.
REQ-027 SHALL ignore start and seed_load while busy=1.
REQ-028 SHALL load DEF_SEED instead when seed=0 is loaded, because xorshift state 0 is absorbing.
REQ-029 SHALL step the RNG as x^=x<<13; x^=x>>17; x^=x<<5 (32-bit), and only in SHUF.

Reset
REQ-030 On rst=1, SHALL set state=IDLE and busy, out_valid, out_last, done and out_data to 0.
REQ-031 On rst=1, SHALL set seq_all to 64'h0123456789ABCDEF (identity) and the RNG to DEF_SEED.
REQ-032 SHALL abort any state immediately on reset with no further out_valid or done; rst SHALL override start.

Structure
REQ-033 SHALL keep N_ELEM, the entry width (4), DEF_SEED and the FSM state enum in a shared package, perm_pkg.
REQ-034 SHALL place the RNG in one sub-module, xorshift32_ld (clk, rst, load, seed, step, res), reusable by the existing generator.

Verification
REQ-035 Reset, seed_load with seed=32'h1, then start -> out_valid rises exactly 16 edges later; 16 beats each a distinct value 0..15; out_last only on beat 16.
REQ-036 Identical seed loaded twice, each followed by start -> both runs produce identical seq_all and beat streams; seed=32'h2 -> a different sequence.
REQ-037 out_ready held 0 for 5 cycles at beat 3, then toggled every cycle -> out_data stable while stalled; no beat lost or duplicated; done one cycle after the last transfer.
REQ-038 start pulsed during SHUF and EMIT, and seed_load pulsed during EMIT -> ignored; the sequence is unchanged and no second run starts.
REQ-039 rst asserted mid-EMIT after beat 7 -> next edge: out_valid=0, busy=0, seq_all=64'h0123456789ABCDEF; a new start completes normally.
REQ-040 seed_load with seed=0, then start -> output is identical to the run after reset with DEF_SEED.
